mgr_noc_dp_arb: RTL

Packet-level round-robin arbiter that shares the manager's single NoC data-path transmit port among `NUM_REQ` upstream requesters, such as the return-data processor and the return-control processor. It sits between those requesters and the `noc_cntl` data-path input. It replaces the hard-tied ready signals currently used in the manager. Packets are never interleaved, and a one-beat output register isolates NoC back-pressure timing.

---
 rtl/mgr_noc_dp_arb_pkg.sv | 25 ++
 rtl/mgr_noc_dp_arb_rr_arb_pick.sv | 29 ++
 rtl/mgr_noc_dp_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mgr_noc_dp_arb_pkg.sv
// Shared manager definitions: stream cntl codes, arbiter states,
// default data-path widths and the round-robin pointer helper.
package mgr_noc_dp_arb_pkg;

   localparam logic [1:0] CNTL_MOD     = 2'b00;
   localparam logic [1:0] CNTL_SOD     = 2'b01;
   localparam logic [1:0] CNTL_EOD     = 2'b10;
   localparam logic [1:0] CNTL_SOD_EOD = 2'b11;

   localparam int STACK_UP_DATA_W   = 64;
   localparam int STACK_DOWN_TAG_W  = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   function automatic int unsigned rr_next(
      input int unsigned idx,
      input int unsigned n
   );
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mgr_noc_dp_arb_rr_arb_pick.sv
// Combinational round-robin picker: first set req bit at or above
// ptr, wrapping modulo N.
module rr_arb_pick #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] w_idx;

   // Walk from the farthest offset down so the nearest hit wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      w_idx     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         w_idx = IDX_W'((32'(ptr) + 32'(i)) % N);
         if (req[w_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = w_idx;
         end
      end
   end

endmodule

// File: rtl/mgr_noc_dp_arb.sv
// Packet-level round-robin arbiter sharing the manager NoC
// data-path transmit port, with a one-beat output register.
module mgr_noc_dp_arb
   import mgr_noc_dp_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = STACK_UP_DATA_W,
   parameter int TAG_W   = STACK_DOWN_TAG_W,
   parameter int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset_poweron,
   input  logic [NUM_REQ-1:0]        req__arb__valid,
   input  logic [2*NUM_REQ-1:0]      req__arb__cntl,
   input  logic [DATA_W*NUM_REQ-1:0] req__arb__data,
   input  logic [TAG_W*NUM_REQ-1:0]  req__arb__tag,
   output logic [NUM_REQ-1:0]        arb__req__ready,
   output logic                      arb__noc__dp_valid,
   output logic [1:0]                arb__noc__dp_cntl,
   output logic [DATA_W-1:0]         arb__noc__dp_data,
   output logic [TAG_W-1:0]          arb__noc__dp_tag,
   output logic [SRC_W-1:0]          arb__noc__dp_srcId,
   input  logic                      noc__arb__dp_ready,
   output logic                      arb__sys__err,
   input  logic                      sys__arb__err_clr
);

   arb_state_e         r_state;
   arb_state_e         w_state_nxt;
   logic [SRC_W-1:0]   r_owner;
   logic [SRC_W-1:0]   w_owner_nxt;
   logic [SRC_W-1:0]   r_ptr;
   logic [SRC_W-1:0]   w_ptr_nxt;

   logic               w_gnt_valid;
   logic [SRC_W-1:0]   w_gnt_idx;
   logic [SRC_W-1:0]   w_sel;
   logic [SRC_W-1:0]   w_sel_inc;
   logic               w_sel_valid;
   logic               w_out_free;
   logic               w_acc;
   logic               w_fwd;
   logic               w_err;
   logic [1:0]         w_cntl;
   logic [DATA_W-1:0]  w_data;
   logic [TAG_W-1:0]   w_tag;

   logic               r_valid;
   logic [1:0]         r_cntl;
   logic [DATA_W-1:0]  r_data;
   logic [TAG_W-1:0]   r_tag;
   logic [SRC_W-1:0]   r_src;
   logic               r_err;

   rr_arb_pick #(
      .N     (NUM_REQ),
      .IDX_W (SRC_W)
   ) u_pick (
      .req       (req__arb__valid),
      .ptr       (r_ptr),
      .gnt_valid (w_gnt_valid),
      .gnt_idx   (w_gnt_idx)
   );

   assign w_out_free  = !r_valid || noc__arb__dp_ready;
   assign w_sel       = (r_state == ST_BUSY) ? r_owner : w_gnt_idx;
   assign w_sel_valid = (r_state == ST_BUSY) ? req__arb__valid[r_owner]
                                             : w_gnt_valid;
   assign w_sel_inc   = SRC_W'(rr_next(32'(w_sel), NUM_REQ));

   // Ready never depends on payload; held low while reset is asserted.
   assign w_acc           = reset_poweron && w_out_free && w_sel_valid;
   assign arb__req__ready = w_acc ? (NUM_REQ'(1) << w_sel) : '0;

   assign w_cntl = req__arb__cntl[32'(w_sel)*2 +: 2];
   assign w_data = req__arb__data[32'(w_sel)*DATA_W +: DATA_W];
   assign w_tag  = req__arb__tag[32'(w_sel)*TAG_W +: TAG_W];

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_fwd       = 1'b0;
      w_err       = 1'b0;
      if (w_acc) begin
         unique case (r_state)
            ST_IDLE: begin
               case (w_cntl)
                  CNTL_SOD: begin
                     w_fwd       = 1'b1;
                     w_owner_nxt = w_sel;
                     w_state_nxt = ST_BUSY;
                  end
                  CNTL_SOD_EOD: begin
                     w_fwd     = 1'b1;
                     w_ptr_nxt = w_sel_inc;
                  end
                  default: begin
                     w_err     = 1'b1;
                     w_ptr_nxt = w_sel_inc;
                  end
               endcase
            end
            ST_BUSY: begin
               w_fwd = 1'b1;
               case (w_cntl)
                  CNTL_EOD: begin
                     w_state_nxt = ST_IDLE;
                     w_ptr_nxt   = w_sel_inc;
                  end
                  CNTL_MOD: ;
                  default:  w_err = 1'b1;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         r_state <= ST_IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         r_valid <= 1'b0;
         r_cntl  <= '0;
         r_data  <= '0;
         r_tag   <= '0;
         r_src   <= '0;
      end else if (w_fwd) begin
         r_valid <= 1'b1;
         r_cntl  <= w_cntl;
         r_data  <= w_data;
         r_tag   <= w_tag;
         r_src   <= w_sel;
      end else if (noc__arb__dp_ready) begin
         r_valid <= 1'b0;
      end
   end

   // A new error in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         r_err <= 1'b0;
      end else if (w_err) begin
         r_err <= 1'b1;
      end else if (sys__arb__err_clr) begin
         r_err <= 1'b0;
      end
   end

   assign arb__noc__dp_valid = r_valid;
   assign arb__noc__dp_cntl  = r_cntl;
   assign arb__noc__dp_data  = r_data;
   assign arb__noc__dp_tag   = r_tag;
   assign arb__noc__dp_srcId = r_src;
   assign arb__sys__err      = r_err;

endmodule
